// File: rtl/mux_2_1_arbiter.sv
// Round-robin arbiter sharing one registered 2:1 mux output stage between requesters A and B.
// Define MUX_2_1_ARB_BURST_EN to let a winner keep the grant for up to MAX_BURST contended cycles.
module mux_2_1_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic          GRANT_A = 1'b0;
    localparam logic          GRANT_B = 1'b1;

    logic [CW-1:0] cnt;
    logic          load;
    logic          win_valid;
    logic          win_b;

    // Handshake: a requester word moves when req_x && ack_x; the output word moves when
    // out_valid && out_ready. The stage reloads whenever it is empty or being drained.
    assign load = !rst && (!out_valid || out_ready);

    always_comb begin
        win_valid = 1'b0;
        win_b     = GRANT_A;
        if (load) begin
            if (req_a && req_b) begin
                win_valid = 1'b1;
`ifdef MUX_2_1_ARB_BURST_EN
                win_b = (cnt < CNT_MAX) ? sel : !sel;
`else
                win_b = !sel;
`endif
            end else if (req_a) begin
                win_valid = 1'b1;
                win_b     = GRANT_A;
            end else if (req_b) begin
                win_valid = 1'b1;
                win_b     = GRANT_B;
            end
        end
    end

    assign ack_a = win_valid && (win_b == GRANT_A);
    assign ack_b = win_valid && (win_b == GRANT_B);

    // Reset leaves sel on B with a full count so A wins the first contention in either build.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= GRANT_B;
            cnt       <= CNT_MAX;
        end else if (load) begin
            if (win_valid) begin
                out_valid <= 1'b1;
                out_data  <= win_b ? data_b : data_a;
                if (win_b == sel) begin
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                end else begin
                    sel <= win_b;
                    cnt <= CW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Bench for mux_2_1_arbiter: vector table, hand-written corner sequences and a random run
// checked against a winner-history model.
module tb_mux_2_1_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, req_b, ack_a, ack_b;
    logic [WIDTH-1:0] data_a, data_b, out_data;
    logic             out_valid, out_ready, sel;

    int total = 0;
    int bad   = 0;

    // Model state: full history of winners (0 = A, 1 = B) plus the output stage contents.
    bit               hist[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic             ra;
        logic [WIDTH-1:0] da;
        logic             rb;
        logic [WIDTH-1:0] db;
        logic             ordy;
        logic             e_ack_a;
        logic             e_ack_b;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic             e_sel;
    } vec_t;

    vec_t vecs[9];

    mux_2_1_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit last_win();
        return hist[hist.size()-1];
    endfunction

    // Length of the trailing run of identical winners, capped at MAX_BURST.
    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (n >= MAX_BURST || hist[i] != last_win()) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < MAX_BURST; i++) hist.push_back(1'b1);
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // -1 = no winner, 0 = A, 1 = B
    function automatic int model_winner(logic rst_v, logic ra, logic rb, logic ordy);
        if (rst_v) return -1;
        if (m_valid && !ordy) return -1;
        if (ra && rb) begin
`ifdef MUX_2_1_ARB_BURST_EN
            if (run_len() < MAX_BURST) return int'(last_win());
`endif
            return int'(!last_win());
        end
        if (ra) return 0;
        if (rb) return 1;
        return -1;
    endfunction

    task automatic step(input logic rst_v, input logic ra, input logic [WIDTH-1:0] da,
                        input logic rb, input logic [WIDTH-1:0] db, input logic ordy);
        int w;
        @(negedge clk);
        rst = rst_v; req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = ordy;
        #1;
        w = model_winner(rst_v, ra, rb, ordy);
        check("ack_a", 32'(ack_a), 32'(w == 0));
        check("ack_b", 32'(ack_b), 32'(w == 1));
        @(posedge clk);
        if (rst_v) begin
            model_reset();
        end else if (w >= 0) begin
            hist.push_back(w[0]);
            m_valid = 1'b1;
            m_data  = (w == 1) ? db : da;
        end else if (!m_valid || ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("sel", 32'(sel), 32'(last_win()));
        check("cnt", 32'(dut.cnt), 32'(run_len()));
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
        model_reset();

        vecs[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
        vecs[3] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1};
        vecs[7] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1};
        vecs[8] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};

        // Reset held two cycles with random requests on the inputs.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_sel", 32'(sel), 32'd1);

        // Vector table, starting from the reset state.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst = 1'b0; req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db; out_ready = vecs[i].ordy;
            #1;
            check("vec_ack_a", 32'(ack_a), 32'(vecs[i].e_ack_a));
            check("vec_ack_b", 32'(ack_b), 32'(vecs[i].e_ack_b));
            @(posedge clk);
            #1;
            check("vec_valid", 32'(out_valid), 32'(vecs[i].e_valid));
            check("vec_data", 32'(out_data), 32'(vecs[i].e_data));
            check("vec_sel", 32'(sel), 32'(vecs[i].e_sel));
        end

        // Contention from reset: 9 back-to-back transfers.
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef MUX_2_1_ARB_BURST_EN
        exp_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hBB, 8'hAA};
`else
        exp_q = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA};
`endif
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
            if (exp_q.size() > 0) check("contention_word", 32'(out_data), 32'(exp_q.pop_front()));
        end

        // Backpressure: five stalled cycles, then release without a bubble.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);

        // Reset while a word is held; A wins the first contention afterwards.
        step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
        check("midreset_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        check("midreset_first", 32'(out_data), 32'hAA);

        // B alone saturates the count; A joining wins the next contention.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hB0 + i), 1'b1);
        check("sat_cnt", 32'(dut.cnt), 32'(MAX_BURST));
        step(1'b0, 1'b1, 8'hA7, 1'b1, 8'hB7, 1'b1);
        check("sat_winner", 32'(out_data), 32'hA7);
        check("sat_sel", 32'(sel), 32'd0);
        check("sat_cnt_after", 32'(dut.cnt), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom),
                 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
